// File: rtl/bv2_scl_pipe_pkg.sv
// Shared GF(2^2) scaler types and the per-share linear map
// used by bv2_scl_pipe and other normal-basis scalers.
package bv2_scl_pipe_pkg;

  localparam int BV2_W = 2;

  typedef logic [BV2_W-1:0] bv2_t;

  typedef enum logic [2:0] {
    SCL_ONE      = 3'd0,
    SCL_OMEGA    = 3'd1,
    SCL_SIGMA    = 3'd2,
    SCL_SQUARE   = 3'd3,
    SCL_SQ_SIGMA = 3'd4
  } scl_op_t;

  // Unknown codes fall back to identity.
  function automatic bv2_t bv2_scl_op(
    bv2_t    a,
    scl_op_t op
  );
    bv2_t b;
    case (op)
      SCL_OMEGA:    b = {a[0] ^ a[1], a[1]};
      SCL_SIGMA:    b = {a[0], a[0] ^ a[1]};
      SCL_SQUARE:   b = {a[0], a[1]};
      SCL_SQ_SIGMA: b = {a[1], a[0] ^ a[1]};
      default:      b = a;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/bv2_scl_stage.sv
// One elastic valid/ready register slice.
// Ports: clock, reset, in_valid/out_ready, out_valid/in_ready, in_dat/out_dat.
module bv2_scl_stage #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         out_ready,
  output logic         out_valid,
  input  logic         in_ready,
  input  logic [W-1:0] in_dat,
  output logic [W-1:0] out_dat
);

  logic adv;

  assign adv       = !out_valid | in_ready;
  assign out_ready = adv;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_dat   <= '0;
    end else if (adv) begin
      out_valid <= in_valid;
      out_dat   <= in_dat;
    end
  end

endmodule

// File: rtl/bv2_scl_pipe.sv
// Share-wise GF(2^2) linear map followed by NUM_STAGES elastic slices.
// Ports: in_a/in_op/in_valid/out_ready in, out_b/out_valid/in_ready out, out_busy.
module bv2_scl_pipe #(
  parameter int NUM_SHARES = 2,
  parameter int NUM_STAGES = 1
) (
  input  logic                    in_clock,
  input  logic                    in_reset,
  input  logic [NUM_SHARES*2-1:0] in_a,
  input  logic [2:0]              in_op,
  input  logic                    in_valid,
  output logic                    out_ready,
  output logic [NUM_SHARES*2-1:0] out_b,
  output logic                    out_valid,
  input  logic                    in_ready,
  output logic                    out_busy
);

  import bv2_scl_pipe_pkg::*;

  localparam int W = NUM_SHARES * BV2_W;

  logic         vld_c [NUM_STAGES+1];
  logic         rdy_c [NUM_STAGES+1];
  logic [W-1:0] dat_c [NUM_STAGES+1];

  // Each share is mapped on its own; shares never meet.
  always_comb begin
    dat_c[0] = '0;
    for (int i = 0; i < NUM_SHARES; i++) begin
      dat_c[0][2*i +: 2] = bv2_scl_op(in_a[2*i +: 2], scl_op_t'(in_op));
    end
  end

  assign vld_c[0]          = in_valid;
  assign rdy_c[NUM_STAGES] = in_ready;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    bv2_scl_stage #(
      .W (W)
    ) u_stage (
      .clock     (in_clock),
      .reset     (in_reset),
      .in_valid  (vld_c[k]),
      .out_ready (rdy_c[k]),
      .out_valid (vld_c[k+1]),
      .in_ready  (rdy_c[k+1]),
      .in_dat    (dat_c[k]),
      .out_dat   (dat_c[k+1])
    );
  end

  assign out_ready = rdy_c[0];
  assign out_valid = vld_c[NUM_STAGES];
  assign out_b     = dat_c[NUM_STAGES];

  always_comb begin
    out_busy = 1'b0;
    for (int k = 1; k <= NUM_STAGES; k++) begin
      out_busy = out_busy | vld_c[k];
    end
  end

endmodule

// File: tb/tb_bv2_scl_pipe.sv
// Bench for bv2_scl_pipe: op table, streaming, stall, bubble,
// reset mid-flight and share independence on three instances.
module tb_bv2_scl_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  // a: 2 shares, 1 stage; b: 2 shares, 3 stages; c: 3 shares, 2 stages
  logic [3:0] a_in_a = '0, a_out_b;
  logic [2:0] a_in_op = '0;
  logic       a_in_valid = 1'b0, a_out_ready, a_out_valid;
  logic       a_in_ready = 1'b1, a_out_busy;

  logic [3:0] b_in_a = '0, b_out_b;
  logic [2:0] b_in_op = '0;
  logic       b_in_valid = 1'b0, b_out_ready, b_out_valid;
  logic       b_in_ready = 1'b1, b_out_busy;

  logic [5:0] c_in_a = '0, c_out_b;
  logic [2:0] c_in_op = '0;
  logic       c_in_valid = 1'b0, c_out_ready, c_out_valid;
  logic       c_in_ready = 1'b1, c_out_busy;

  bv2_scl_pipe #(.NUM_SHARES(2), .NUM_STAGES(1)) dut_a (
    .in_clock(clk), .in_reset(rst), .in_a(a_in_a), .in_op(a_in_op),
    .in_valid(a_in_valid), .out_ready(a_out_ready), .out_b(a_out_b),
    .out_valid(a_out_valid), .in_ready(a_in_ready), .out_busy(a_out_busy)
  );

  bv2_scl_pipe #(.NUM_SHARES(2), .NUM_STAGES(3)) dut_b (
    .in_clock(clk), .in_reset(rst), .in_a(b_in_a), .in_op(b_in_op),
    .in_valid(b_in_valid), .out_ready(b_out_ready), .out_b(b_out_b),
    .out_valid(b_out_valid), .in_ready(b_in_ready), .out_busy(b_out_busy)
  );

  bv2_scl_pipe #(.NUM_SHARES(3), .NUM_STAGES(2)) dut_c (
    .in_clock(clk), .in_reset(rst), .in_a(c_in_a), .in_op(c_in_op),
    .in_valid(c_in_valid), .out_ready(c_out_ready), .out_b(c_out_b),
    .out_valid(c_out_valid), .in_ready(c_in_ready), .out_busy(c_out_busy)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
  endtask

  // Reference: the op table applied to one (a1,a0) share.
  function automatic logic [1:0] ref_share(logic [1:0] a, logic [2:0] op);
    logic a1, a0;
    a1 = a[1];
    a0 = a[0];
    case (op)
      3'd1:    return {a0 ^ a1, a1};
      3'd2:    return {a0, a0 ^ a1};
      3'd3:    return {a0, a1};
      3'd4:    return {a1, a0 ^ a1};
      default: return a;
    endcase
  endfunction

  function automatic logic [5:0] ref_word(logic [5:0] a, logic [2:0] op, int s);
    logic [5:0] r;
    r = '0;
    for (int i = 0; i < s; i++) r[2*i +: 2] = ref_share(a[2*i +: 2], op);
    return r;
  endfunction

  typedef struct {
    logic [5:0] dat;
    int         cyc;
  } ent_t;

  ent_t bq[$];
  ent_t cq[$];
  int   cyc = 0;
  int   n_bin = 0, n_bout = 0, n_cout = 0;
  bit   lat_mode = 0;
  bit   stream_mode = 0;
  logic [1:0] c_exp0 = '0, c_exp2 = '0;

  // Scoreboards: outputs popped before inputs pushed in the same cycle.
  always @(negedge clk) begin
    ent_t e;
    cyc++;
    if (!rst) begin
      if (b_out_valid && b_in_ready) begin
        n_bout++;
        if (bq.size() == 0) check("b_spurious_out", 1, 0);
        else begin
          e = bq.pop_front();
          check("b_data", {28'd0, b_out_b}, {26'd0, e.dat});
          if (lat_mode) check("b_latency", cyc - e.cyc, 3);
        end
      end
      if (b_in_valid && b_out_ready) begin
        n_bin++;
        bq.push_back('{ref_word({2'b00, b_in_a}, b_in_op, 2), cyc});
      end
      if (stream_mode) check("b_ready_stream", {31'd0, b_out_ready}, 1);
      if (c_out_valid && c_in_ready) begin
        n_cout++;
        check("c_share0", {30'd0, c_out_b[1:0]}, {30'd0, c_exp0});
        check("c_share2", {30'd0, c_out_b[5:4]}, {30'd0, c_exp2});
        if (cq.size() == 0) check("c_spurious_out", 1, 0);
        else begin
          e = cq.pop_front();
          check("c_data", {26'd0, c_out_b}, {26'd0, e.dat});
        end
      end
      if (c_in_valid && c_out_ready)
        cq.push_back('{ref_word(c_in_a, c_in_op, 3), cyc});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] exp;
  } vec_t;

  vec_t vt[9];

  initial begin
    logic [3:0] held;
    bit         pend;
    int         base;

    vt[0] = '{"sigma",    3'd2, 4'b1001, 4'b0111};
    vt[1] = '{"omega",    3'd1, 4'b1001, 4'b1110};
    vt[2] = '{"square",   3'd3, 4'b1001, 4'b0110};
    vt[3] = '{"sq_sigma", 3'd4, 4'b1001, 4'b1101};
    vt[4] = '{"one",      3'd0, 4'b1001, 4'b1001};
    vt[5] = '{"op5",      3'd5, 4'b1001, 4'b1001};
    vt[6] = '{"op7",      3'd7, 4'b1001, 4'b1001};
    vt[7] = '{"omega2",   3'd1, 4'b0111, 4'b1001};
    vt[8] = '{"square2",  3'd3, 4'b0111, 4'b1011};

    // Reset values
    #2;
    check("rst_a_valid", {31'd0, a_out_valid}, 0);
    check("rst_a_b",     {28'd0, a_out_b}, 0);
    check("rst_a_busy",  {31'd0, a_out_busy}, 0);
    check("rst_a_ready", {31'd0, a_out_ready}, 1);
    check("rst_b_valid", {31'd0, b_out_valid}, 0);
    check("rst_b_ready", {31'd0, b_out_ready}, 1);
    check("rst_c_valid", {31'd0, c_out_valid}, 0);
    check("rst_c_busy",  {31'd0, c_out_busy}, 0);
    @(posedge clk);
    step();
    rst = 1'b0;

    // Op sweep, 1 stage
    foreach (vt[i]) begin
      a_in_valid = 1'b1;
      a_in_op    = vt[i].op;
      a_in_a     = vt[i].a;
      step();
      check({"op_", vt[i].name, "_valid"}, {31'd0, a_out_valid}, 1);
      check({"op_", vt[i].name}, {28'd0, a_out_b}, {28'd0, vt[i].exp});
    end
    a_in_valid = 1'b0;
    step();
    check("op_drain_valid", {31'd0, a_out_valid}, 0);
    check("op_drain_busy",  {31'd0, a_out_busy}, 0);

    // Streaming, 3 stages
    base = n_bout;
    lat_mode = 1;
    stream_mode = 1;
    for (int i = 0; i < 8; i++) begin
      b_in_valid = 1'b1;
      b_in_a     = 4'($urandom);
      b_in_op    = 3'($urandom);
      step();
    end
    b_in_valid = 1'b0;
    repeat (5) step();
    lat_mode = 0;
    stream_mode = 0;
    check("stream_count", n_bout - base, 8);

    // Stall
    b_in_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b_in_valid = 1'b1;
      b_in_a     = 4'($urandom);
      b_in_op    = 3'($urandom);
      step();
    end
    b_in_valid = 1'b1;
    b_in_a     = 4'($urandom);
    held = b_out_b;
    for (int i = 0; i < 5; i++) begin
      check("stall_ready", {31'd0, b_out_ready}, 0);
      check("stall_valid", {31'd0, b_out_valid}, 1);
      check("stall_hold",  {28'd0, b_out_b}, {28'd0, held});
      step();
    end
    b_in_valid = 1'b0;
    b_in_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("drain_valid", {31'd0, b_out_valid}, 1);
      step();
    end
    check("drain_done", {31'd0, b_out_valid}, 0);

    // Bubble with toggling back-pressure
    pend = 0;
    for (int i = 0; i < 40; i++) begin
      if (!pend) begin
        b_in_valid = (i % 2) == 0;
        b_in_a     = 4'($urandom);
        b_in_op    = 3'($urandom);
      end
      b_in_ready = ((i / 2) % 2) == 0;
      @(negedge clk);
      pend = b_in_valid && !b_out_ready;
      step();
    end
    b_in_valid = 1'b0;
    b_in_ready = 1'b1;
    repeat (6) step();
    check("bubble_empty", bq.size(), 0);
    check("bubble_balance", n_bout, n_bin);

    // Reset mid-flight
    b_in_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      b_in_valid = 1'b1;
      b_in_a     = 4'($urandom_range(15, 1));
      b_in_op    = 3'd0;
      step();
    end
    b_in_valid = 1'b0;
    step();
    check("pre_rst_valid", {31'd0, b_out_valid}, 1);
    check("pre_rst_busy",  {31'd0, b_out_busy}, 1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, b_out_valid}, 0);
    check("mid_rst_b",     {28'd0, b_out_b}, 0);
    check("mid_rst_busy",  {31'd0, b_out_busy}, 0);
    check("mid_rst_ready", {31'd0, b_out_ready}, 1);
    bq.delete();
    step();
    rst = 1'b0;
    b_in_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("no_stale", {31'd0, b_out_valid}, 0);
      step();
    end

    // Share independence, 3 shares
    c_in_op = 3'($urandom_range(4, 1));
    c_in_a  = 6'($urandom);
    c_exp0  = ref_share(c_in_a[1:0], c_in_op);
    c_exp2  = ref_share(c_in_a[5:4], c_in_op);
    for (int i = 0; i < 20; i++) begin
      c_in_valid   = 1'b1;
      c_in_a[3:2]  = 2'($urandom);
      step();
    end
    c_in_valid = 1'b0;
    repeat (4) step();
    check("share_count", n_cout, 20);
    check("share_empty", cq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
